// File: rtl/alu_bcd_converter.sv
// alu_bcd_converter
//   Sequential signed-binary to BCD converter (shift-and-add-3 / double dabble)
//   feeding the display data stage. A conversion takes the two's-complement
//   ALU result, strips the sign, and produces DIGITS BCD digits of magnitude.
//   Results are only published when a conversion completes, so the display
//   never sees partial values.
//
// Ports
//   clk      in   system clock, rising edge
//   rst      in   synchronous, active-high reset
//   start    in   conversion request, sampled only while idle
//   bin_in   in   [BIN_WIDTH-1:0] signed ALU result
//   busy     out  high while converting (CONV and DONE states)
//   done     out  one-cycle pulse in the cycle bcd_out/sign_out take a new value
//   bcd_out  out  [4*DIGITS-1:0] BCD magnitude, most significant digit on top
//   sign_out out  1 = negative result
module alu_bcd_converter #(
    parameter int BIN_WIDTH = 10,
    parameter int DIGITS    = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [BIN_WIDTH-1:0]  bin_in,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd_out,
    output logic                  sign_out
);

    localparam int BCD_W = 4 * DIGITS;
    localparam int CNT_W = (BIN_WIDTH > 1) ? $clog2(BIN_WIDTH) : 1;
    localparam logic [CNT_W-1:0]     CNT_LAST = CNT_W'(BIN_WIDTH - 1);
    localparam logic [CNT_W-1:0]     CNT_ONE  = CNT_W'(1);
    localparam logic [BIN_WIDTH-1:0] BIN_ONE  = BIN_WIDTH'(1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CONV,
        S_DONE
    } state_t;

    state_t               state_q, state_d;
    logic [BIN_WIDTH-1:0] mag_q, mag_d;
    logic [BCD_W-1:0]     bcd_q, bcd_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 sign_q, sign_d;
    logic [BCD_W-1:0]     bcd_out_q, bcd_out_d;
    logic                 sign_out_q, sign_out_d;

    // Add-3 correction: any digit >= 5 would exceed 9 after doubling, so it is
    // pre-biased by 3 to carry correctly into the next digit on the shift.
    logic [BCD_W-1:0]     bcd_adj;

    always_comb begin
        bcd_adj = bcd_q;
        for (int i = 0; i < DIGITS; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) begin
                bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        mag_d      = mag_q;
        bcd_d      = bcd_q;
        cnt_d      = cnt_q;
        sign_d     = sign_q;
        bcd_out_d  = bcd_out_q;
        sign_out_d = sign_out_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    sign_d  = bin_in[BIN_WIDTH-1];
                    // Two's-complement negate; the most negative value maps to
                    // itself, which read as unsigned is the correct magnitude.
                    mag_d   = bin_in[BIN_WIDTH-1] ? (~bin_in + BIN_ONE) : bin_in;
                    bcd_d   = '0;
                    cnt_d   = '0;
                    state_d = S_CONV;
                end
            end
            S_CONV: begin
                bcd_d = {bcd_adj[BCD_W-2:0], mag_q[BIN_WIDTH-1]};
                mag_d = mag_q << 1;
                cnt_d = cnt_q + CNT_ONE;
                if (cnt_q == CNT_LAST) begin
                    // Publish on the final shift so the outputs change on the
                    // same edge that raises done.
                    bcd_out_d  = {bcd_adj[BCD_W-2:0], mag_q[BIN_WIDTH-1]};
                    sign_out_d = sign_q;
                    state_d    = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            mag_q      <= '0;
            bcd_q      <= '0;
            cnt_q      <= '0;
            sign_q     <= 1'b0;
            bcd_out_q  <= '0;
            sign_out_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            mag_q      <= mag_d;
            bcd_q      <= bcd_d;
            cnt_q      <= cnt_d;
            sign_q     <= sign_d;
            bcd_out_q  <= bcd_out_d;
            sign_out_q <= sign_out_d;
        end
    end

    assign busy     = (state_q != S_IDLE);
    assign done     = (state_q == S_DONE);
    assign bcd_out  = bcd_out_q;
    assign sign_out = sign_out_q;

endmodule

// File: tb/tb_alu_bcd_converter.sv
// Self-checking bench for alu_bcd_converter: table-driven vectors, hand-written
// multi-cycle sequences (ignored start, held start, reset abort) and random
// values checked against a decimal-arithmetic reference model.
module tb_alu_bcd_converter;

    localparam int BW = 10;
    localparam int DG = 3;

    logic            clk = 1'b0;
    logic            rst;
    logic            start;
    logic [BW-1:0]   bin_in;
    logic            busy;
    logic            done;
    logic [4*DG-1:0] bcd_out;
    logic            sign_out;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    alu_bcd_converter #(.BIN_WIDTH(BW), .DIGITS(DG)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .bin_in   (bin_in),
        .busy     (busy),
        .done     (done),
        .bcd_out  (bcd_out),
        .sign_out (sign_out)
    );

    typedef struct {
        logic [BW-1:0]   bin;
        logic [4*DG-1:0] bcd;
        logic            sgn;
    } vec_t;

    vec_t tbl[12];

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Advance one clock; outputs are then observed 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference: magnitude in plain decimal arithmetic, digits by div/mod.
    function automatic logic [4*DG-1:0] ref_bcd(input logic [BW-1:0] v);
        int m;
        m = $signed(v);
        if (m < 0) m = -m;
        return {4'(m / 100), 4'((m / 10) % 10), 4'(m % 10)};
    endfunction

    function automatic logic ref_sign(input logic [BW-1:0] v);
        int m;
        m = $signed(v);
        return (m < 0);
    endfunction

    // Full conversion: start in cycle 0, expect done in cycle 11 with busy
    // high throughout, then idle in cycle 12 with the result held.
    task automatic convert(input logic [BW-1:0] v, input logic [4*DG-1:0] eb,
                           input logic es, input string nm);
        int cyc;
        logic [4*DG-1:0] held;
        start  = 1'b1;
        bin_in = v;
        step();
        start  = 1'b0;
        bin_in = BW'($urandom);   // must not disturb the conversion
        cyc = 1;
        while (!done && cyc < 40) begin
            chk({nm, " busy during conv"}, int'(busy), 1);
            step();
            cyc++;
        end
        chk({nm, " latency"}, cyc, 11);
        chk({nm, " busy at done"}, int'(busy), 1);
        chk({nm, " bcd"}, int'(bcd_out), int'(eb));
        chk({nm, " sign"}, int'(sign_out), int'(es));
        for (int d = 0; d < DG; d++)
            chk({nm, " digit range"}, int'(bcd_out[4*d +: 4] <= 4'd9), 1);
        held = bcd_out;
        step();
        chk({nm, " busy after"}, int'(busy), 0);
        chk({nm, " done width"}, int'(done), 0);
        chk({nm, " hold"}, int'(bcd_out), int'(held));
    endtask

    initial begin
        int c, ndone, c1, c2;
        logic [BW-1:0] rv;

        tbl[0]  = '{10'd0,   12'h000, 1'b0};
        tbl[1]  = '{10'd123, 12'h123, 1'b0};
        tbl[2]  = '{10'd511, 12'h511, 1'b0};
        tbl[3]  = '{10'h39D, 12'h099, 1'b1};   // -99
        tbl[4]  = '{10'h200, 12'h512, 1'b1};   // -512
        tbl[5]  = '{10'd1,   12'h001, 1'b0};
        tbl[6]  = '{10'h3FF, 12'h001, 1'b1};   // -1
        tbl[7]  = '{10'd9,   12'h009, 1'b0};
        tbl[8]  = '{10'd10,  12'h010, 1'b0};
        tbl[9]  = '{10'd99,  12'h099, 1'b0};
        tbl[10] = '{10'd100, 12'h100, 1'b0};
        tbl[11] = '{10'h201, 12'h511, 1'b1};   // -511

        rst = 1'b1; start = 1'b0; bin_in = '0;
        repeat (3) step();
        chk("reset busy", int'(busy), 0);
        chk("reset done", int'(done), 0);
        chk("reset bcd", int'(bcd_out), 0);
        chk("reset sign", int'(sign_out), 0);
        rst = 1'b0;
        step();

        for (int i = 0; i < 12; i++)
            convert(tbl[i].bin, tbl[i].bcd, tbl[i].sgn, $sformatf("vec%0d", i));

        // Start pulse while busy is ignored.
        start = 1'b1; bin_in = 10'd45;
        step();
        start = 1'b0;
        ndone = 0; c1 = 0;
        for (c = 1; c <= 14; c++) begin
            if (done) begin
                ndone++;
                c1 = c;
                chk("ignore bcd", int'(bcd_out), 'h045);
                chk("ignore sign", int'(sign_out), 0);
            end
            if (c == 5) begin start = 1'b1; bin_in = 10'h3F9; end
            else start = 1'b0;
            step();
        end
        chk("ignore done count", ndone, 1);
        chk("ignore done cycle", c1, 11);
        chk("ignore idle", int'(busy), 0);
        chk("ignore held bcd", int'(bcd_out), 'h045);
        convert(10'h3F9, 12'h007, 1'b1, "neg7");

        // start held high: back-to-back conversions 12 cycles apart.
        start = 1'b1; bin_in = 10'd200;
        step();
        bin_in = 10'h2D4;   // -300
        c = 1; ndone = 0; c1 = 0; c2 = 0;
        while (c <= 40 && ndone < 2) begin
            if (done) begin
                ndone++;
                if (ndone == 1) begin
                    c1 = c;
                    chk("held first bcd", int'(bcd_out), 'h200);
                    chk("held first sign", int'(sign_out), 0);
                end else begin
                    c2 = c;
                    chk("held second bcd", int'(bcd_out), 'h300);
                    chk("held second sign", int'(sign_out), 1);
                end
            end else if (ndone == 1) begin
                chk("held stable bcd", int'(bcd_out), 'h200);
                chk("held stable sign", int'(sign_out), 0);
                chk("held busy", int'(busy), int'(c != 12));
            end
            step();
            c++;
        end
        start = 1'b0;
        chk("held first cycle", c1, 11);
        chk("held second cycle", c2, 23);
        step(); step();
        chk("held idle", int'(busy), 0);

        // Reset mid-conversion aborts without a done pulse.
        convert(10'd77, 12'h077, 1'b0, "seventy7");
        start = 1'b1; bin_in = 10'd88;
        step();
        start = 1'b0;
        for (c = 1; c <= 4; c++) begin
            chk("abort no done", int'(done), 0);
            if (c == 4) rst = 1'b1;
            step();
        end
        chk("abort busy", int'(busy), 0);
        chk("abort done", int'(done), 0);
        chk("abort bcd", int'(bcd_out), 0);
        chk("abort sign", int'(sign_out), 0);
        rst = 1'b0;
        step();
        chk("abort still idle", int'(busy), 0);
        convert(10'd88, 12'h088, 1'b0, "eighty8");

        // Reset wins over start in the same cycle.
        rst = 1'b1; start = 1'b1; bin_in = 10'd5;
        step();
        chk("rst priority busy", int'(busy), 0);
        rst = 1'b0; start = 1'b0;
        step();
        chk("rst priority idle", int'(busy), 0);

        // Random values against the reference model.
        for (int k = 0; k < 40; k++) begin
            rv = BW'($urandom);
            convert(rv, ref_bcd(rv), ref_sign(rv), $sformatf("rand%0d", k));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
